inst_buffer: RTL and testbench

- Dual-lane instruction queue between fetch and the two decode slots.
- Accepts up to 2 fetched instructions per cycle, each carrying its pc, raw inst, pre-decoded operation and fetch exception.
- Presents up to 2 micro-ops per cycle to the decoders.
- Splits HI/LO-pair operations (MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MUL) into two consecutive micro-ops, driving is_inst2 = 0 then 1.

---
 rtl/inst_buffer_pkg.sv | 33 +++
 rtl/inst_buf_uop_select.sv | 78 +++++++
 rtl/inst_buffer.sv | 138 +++++++++++++
 tb/tb_inst_buffer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_buffer_pkg.sv
// Shared types for the instruction buffer: operations, exceptions, the
// stored entry layout and the HI/LO-pair split classification.
package inst_buffer_pkg;

  localparam int unsigned INST_BUF_DEPTH = 16;

  typedef logic [31:0] virt_t;
  typedef logic [31:0] uint32_t;
  typedef logic [3:0]  exception_t;

  typedef enum logic [4:0] {
    OP_SLL, OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_LW, OP_SW, OP_BEQ, OP_J,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU,
    OP_MUL, OP_MFHI, OP_MFLO
  } operation_t;

  typedef struct packed {
    virt_t      pc;
    uint32_t    inst;
    operation_t op;
    exception_t exc;
  } inst_buf_entry_t;

  // Operations whose HI/LO results are produced by two consecutive micro-ops.
  function automatic logic is_split_op(operation_t op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU,
      OP_MSUB, OP_MSUBU, OP_MUL: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/inst_buf_uop_select.sv
// Combinational lane construction from the head (H) and next (N) buffer
// entries. Produces up to two micro-ops, the number of entries to retire
// and the next head_half value. Splitting is enabled by INST_BUF_SPLIT_EN.
module inst_buf_uop_select
  import inst_buffer_pkg::*;
#(
  parameter int unsigned CW = 5
) (
  input  inst_buf_entry_t       head,
  input  inst_buf_entry_t       next,
  input  logic [CW-1:0]         count,
`ifdef INST_BUF_SPLIT_EN
  input  logic                  head_half,
  output logic                  head_half_next,
`endif
  output logic [1:0]            lane_valid,
  output inst_buf_entry_t [1:0] lane,
  output logic [1:0]            lane_is_inst2,
  output logic [1:0]            pop_cnt
);

  logic split_h;
  logic split_n;
  logic half;
  logic half_next;

`ifdef INST_BUF_SPLIT_EN
  // An excepting entry is never split; it issues once as the first half.
  assign split_h = is_split_op(head.op) && (head.exc == '0);
  assign split_n = is_split_op(next.op) && (next.exc == '0);
  assign half    = head_half;
  assign head_half_next = half_next;
`else
  assign split_h = 1'b0;
  assign split_n = 1'b0;
  assign half    = 1'b0;
`endif

  // Build the two lanes; invalid lanes are driven to zero.
  always_comb begin
    lane_valid    = '0;
    lane[0]       = '0;
    lane[1]       = '0;
    lane_is_inst2 = '0;
    pop_cnt       = 2'd0;
    half_next     = half;
    if (count != '0) begin
      lane_valid[0] = 1'b1;
      lane[0]       = head;
      if (split_h && !half) begin
        // Both halves of the head issue together, even with count == 1.
        lane_valid[1]    = 1'b1;
        lane[1]          = head;
        lane_is_inst2[1] = 1'b1;
        pop_cnt          = 2'd1;
        half_next        = 1'b0;
      end else begin
        // Head is either non-split or already half issued (second half now).
        lane_is_inst2[0] = split_h;
        if (count >= CW'(2)) begin
          lane_valid[1] = 1'b1;
          lane[1]       = next;
          pop_cnt       = split_n ? 2'd1 : 2'd2;
          half_next     = split_n;
        end else begin
          pop_cnt   = 2'd1;
          half_next = 1'b0;
        end
      end
    end
  end

`ifndef INST_BUF_SPLIT_EN
  logic unused_half;
  assign unused_half = half_next;
`endif

endmodule

// File: rtl/inst_buffer.sv
// Dual-lane instruction queue between fetch and the two decode slots.
// Circular storage with wrap-bit pointers; occupancy is the pointer
// difference. HI/LO-pair splitting is enabled by defining INST_BUF_SPLIT_EN.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = INST_BUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [1:0]            in_valid,
  input  logic [1:0][31:0]      in_pc,
  input  logic [1:0][31:0]      in_inst,
  input  operation_t [1:0]      in_op,
  input  exception_t [1:0]      in_exc,
  output logic                  in_ready,
  output logic [1:0]            out_valid,
  output logic [1:0][31:0]      out_pc,
  output logic [1:0][31:0]      out_inst,
  output operation_t [1:0]      out_op,
  output exception_t [1:0]      out_exc,
  output logic [1:0]            out_is_inst2,
  input  logic                  out_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] wr_inc;
  logic [CW-1:0] pop_inc;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] wr_idx1;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] rd_idx1;

  inst_buf_entry_t       mem [DEPTH];
  inst_buf_entry_t       in_entry [2];
  inst_buf_entry_t       head;
  inst_buf_entry_t       next;
  inst_buf_entry_t [1:0] lane;
  logic [1:0]            lane_valid;
  logic [1:0]            lane_is_inst2;
  logic [1:0]            pop_cnt;
  logic                  wr_en;
  logic                  pop_en;

  // Wrap bits make the difference exact even when the pointers alias.
  assign count    = wr_ptr - rd_ptr;
  assign in_ready = (count <= CW'(DEPTH - 2));
  assign wr_idx   = wr_ptr[AW-1:0];
  assign wr_idx1  = wr_idx + AW'(1);
  assign rd_idx   = rd_ptr[AW-1:0];
  assign rd_idx1  = rd_idx + AW'(1);
  assign wr_inc   = CW'(in_valid[0]) + CW'(in_valid[1]);
  assign pop_inc  = CW'(pop_cnt);
  assign wr_en    = in_ready && (in_valid != '0) && !flush;
  assign pop_en   = out_ready && lane_valid[0] && !flush;
  assign head     = mem[rd_idx];
  assign next     = mem[rd_idx1];

  // Pack incoming lanes into storage entries.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      in_entry[i] = '{pc: in_pc[i], inst: in_inst[i], op: in_op[i], exc: in_exc[i]};
    end
  end

  // Storage write; valid lanes are compacted so the oldest lands at wr_ptr.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (in_valid[0]) begin
        mem[wr_idx] <= in_entry[0];
        if (in_valid[1]) mem[wr_idx1] <= in_entry[1];
      end else begin
        mem[wr_idx] <= in_entry[1];
      end
    end
  end

  // Pointer update; flush discards everything and blocks write and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + wr_inc;
      if (pop_en) rd_ptr <= rd_ptr + pop_inc;
    end
  end

`ifdef INST_BUF_SPLIT_EN
  logic head_half;
  logic head_half_next;

  // Tracks whether the head entry's first half has already issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         head_half <= 1'b0;
    else if (flush)  head_half <= 1'b0;
    else if (pop_en) head_half <= head_half_next;
  end
`endif

  inst_buf_uop_select #(
    .CW(CW)
  ) u_sel (
    .head          (head),
    .next          (next),
    .count         (count),
`ifdef INST_BUF_SPLIT_EN
    .head_half     (head_half),
    .head_half_next(head_half_next),
`endif
    .lane_valid    (lane_valid),
    .lane          (lane),
    .lane_is_inst2 (lane_is_inst2),
    .pop_cnt       (pop_cnt)
  );

  // Unpack lanes onto the decode-side ports.
  always_comb begin
    out_valid    = lane_valid;
    out_is_inst2 = lane_is_inst2;
    for (int unsigned i = 0; i < 2; i++) begin
      out_pc[i]   = lane[i].pc;
      out_inst[i] = lane[i].inst;
      out_op[i]   = lane[i].op;
      out_exc[i]  = lane[i].exc;
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: a micro-op level queue model checked
// every cycle, directed scenarios with literal expectations, then random
// traffic with occasional flushes.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int unsigned DEPTH = 16;
`ifdef INST_BUF_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [1:0]       in_valid;
  logic [1:0][31:0] in_pc;
  logic [1:0][31:0] in_inst;
  operation_t [1:0] in_op;
  exception_t [1:0] in_exc;
  logic             in_ready;
  logic [1:0]       out_valid;
  logic [1:0][31:0] out_pc;
  logic [1:0][31:0] out_inst;
  operation_t [1:0] out_op;
  exception_t [1:0] out_exc;
  logic [1:0]       out_is_inst2;
  logic             out_ready;

  always #5 clk = ~clk;

  inst_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_op(in_op), .in_exc(in_exc),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_op(out_op),
    .out_exc(out_exc), .out_is_inst2(out_is_inst2), .out_ready(out_ready)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          run      = 1'b0;

  // Model: queue of whole entries plus "first half of head already taken".
  inst_buf_entry_t q[$];
  bit              hh = 1'b0;

  function automatic bit m_split(inst_buf_entry_t e);
    bit hilo;
    hilo = (e.op == OP_MULT)  || (e.op == OP_MULTU) || (e.op == OP_DIV) ||
           (e.op == OP_DIVU)  || (e.op == OP_MADD)  || (e.op == OP_MADDU) ||
           (e.op == OP_MSUB)  || (e.op == OP_MSUBU) || (e.op == OP_MUL);
    return SPLIT_EN && hilo && (e.exc == 4'd0);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  inst_buf_entry_t ee [2];
  bit              e2 [2];
  int              n;
  bit              m_ready;
  logic [127:0]    exp_lane;
  logic [127:0]    act_lane;

  // Compare DUT against the model, then advance the model by one cycle.
  always @(negedge clk) begin
    if (run) begin
      n = 0;
      ee[0] = '0; ee[1] = '0; e2[0] = 1'b0; e2[1] = 1'b0;
      for (int k = 0; k < q.size() && n < 2; k++) begin
        if (m_split(q[k])) begin
          if (!(k == 0 && hh)) begin ee[n] = q[k]; e2[n] = 1'b0; n++; end
          if (n < 2) begin ee[n] = q[k]; e2[n] = 1'b1; n++; end
        end else begin
          ee[n] = q[k]; e2[n] = 1'b0; n++;
        end
      end
      m_ready = (q.size() <= DEPTH - 2);
      chk("in_ready", 128'(in_ready), 128'(m_ready));
      chk("out_valid", 128'(out_valid), 128'({n >= 2, n >= 1}));
      for (int i = 0; i < 2; i++) begin
        exp_lane = (i < n) ? 128'({ee[i].pc, ee[i].inst, ee[i].op, ee[i].exc, e2[i]}) : '0;
        act_lane = 128'({out_pc[i], out_inst[i], out_op[i], out_exc[i], out_is_inst2[i]});
        chk($sformatf("lane%0d", i), act_lane, exp_lane);
      end
      if (flush) begin
        q.delete();
        hh = 1'b0;
      end else begin
        if (out_ready) begin
          for (int k = 0; k < n; k++) begin
            if (m_split(q[0]) && !hh) hh = 1'b1;
            else begin void'(q.pop_front()); hh = 1'b0; end
          end
        end
        if (m_ready) begin
          if (in_valid[0]) q.push_back('{pc: in_pc[0], inst: in_inst[0], op: in_op[0], exc: in_exc[0]});
          if (in_valid[1]) q.push_back('{pc: in_pc[1], inst: in_inst[1], op: in_op[1], exc: in_exc[1]});
        end
      end
    end
  end

  task automatic drive_lane(input int l, input logic [31:0] pc, input operation_t op,
                            input exception_t exc);
    in_pc[l]   = pc;
    in_inst[l] = $urandom;
    in_op[l]   = op;
    in_exc[l]  = exc;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = '0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0; in_op = {OP_SLL, OP_SLL}; in_exc = '0;
    cyc();
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_fields", 128'({out_pc, out_inst, out_op, out_exc, out_is_inst2}), 128'(0));
    rst = 1'b0;
    run = 1'b1;

    // Two ADDUs held, then drained.
    drive_lane(0, 32'h100, OP_ADDU, 4'd0);
    drive_lane(1, 32'h104, OP_ADDU, 4'd0);
    in_valid = 2'b11; out_ready = 1'b0;
    cyc();
    in_valid = 2'b00;
    chk("t1_valid", 128'(out_valid), 128'(2'b11));
    chk("t1_pc0", 128'(out_pc[0]), 128'(32'h100));
    chk("t1_pc1", 128'(out_pc[1]), 128'(32'h104));
    chk("t1_is2", 128'(out_is_inst2), 128'(2'b00));
    out_ready = 1'b1;
    cyc();
    chk("t1_empty", 128'(out_valid), 128'(2'b00));

    // Lone MULT.
    drive_lane(0, 32'h200, OP_MULT, 4'd0);
    in_valid = 2'b01;
    cyc();
    in_valid = 2'b00;
    chk("t2_valid", 128'(out_valid), SPLIT_EN ? 128'(2'b11) : 128'(2'b01));
    chk("t2_pc0", 128'(out_pc[0]), 128'(32'h200));
    chk("t2_pc1", 128'(out_pc[1]), SPLIT_EN ? 128'(32'h200) : 128'(0));
    chk("t2_is2", 128'(out_is_inst2), SPLIT_EN ? 128'(2'b10) : 128'(2'b00));
    cyc();
    chk("t2_empty", 128'(out_valid), 128'(2'b00));

    // ADDU followed by MADD.
    drive_lane(0, 32'h300, OP_ADDU, 4'd0);
    drive_lane(1, 32'h304, OP_MADD, 4'd0);
    in_valid = 2'b11;
    cyc();
    in_valid = 2'b00;
    chk("t3_c1_valid", 128'(out_valid), 128'(2'b11));
    chk("t3_c1_pcs", 128'({out_pc[0], out_pc[1]}), 128'({32'h300, 32'h304}));
    chk("t3_c1_is2", 128'(out_is_inst2), 128'(2'b00));
    cyc();
    chk("t3_c2_valid", 128'(out_valid), SPLIT_EN ? 128'(2'b01) : 128'(2'b00));
    chk("t3_c2_pc0", 128'(out_pc[0]), SPLIT_EN ? 128'(32'h304) : 128'(0));
    chk("t3_c2_is2", 128'(out_is_inst2), SPLIT_EN ? 128'(2'b01) : 128'(2'b00));
    cyc();
    chk("t3_empty", 128'(out_valid), 128'(2'b00));

    // Fill until full, try more writes, then drain across the pointer wrap.
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive_lane(0, 32'h1000 + 32'(8 * k), OP_ADDU, 4'd0);
      drive_lane(1, 32'h1004 + 32'(8 * k), OP_MULT, 4'd0);
      in_valid = 2'b11;
      cyc();
    end
    in_valid = 2'b00;
    chk("t4_full_ready", 128'(in_ready), 128'(0));
    chk("t4_head_pc", 128'(out_pc[0]), 128'(32'h1000));
    out_ready = 1'b1;
    repeat (20) cyc();
    chk("t4_drained", 128'(out_valid), 128'(2'b00));
    chk("t4_ready", 128'(in_ready), 128'(1));

    // Flush while a DIV is half issued.
    drive_lane(0, 32'h4fc, OP_ADDU, 4'd0);
    drive_lane(1, 32'h500, OP_DIV, 4'd0);
    in_valid = 2'b11;
    cyc();
    drive_lane(0, 32'h510, OP_ADDU, 4'd0);
    drive_lane(1, 32'h514, OP_ADDU, 4'd0);
    flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 2'b00;
    chk("t5_valid", 128'(out_valid), 128'(2'b00));
    chk("t5_ready", 128'(in_ready), 128'(1));
    drive_lane(0, 32'h600, OP_MULT, 4'd0);
    in_valid = 2'b01;
    cyc();
    in_valid = 2'b00;
    chk("t5_post_valid", 128'(out_valid), SPLIT_EN ? 128'(2'b11) : 128'(2'b01));
    chk("t5_post_is2", 128'(out_is_inst2), SPLIT_EN ? 128'(2'b10) : 128'(2'b00));
    cyc();

    // Excepting MUL issues once.
    out_ready = 1'b0;
    drive_lane(0, 32'h700, OP_MUL, 4'h3);
    in_valid = 2'b01;
    cyc();
    in_valid = 2'b00;
    chk("t6_valid", 128'(out_valid), 128'(2'b01));
    chk("t6_lane0", 128'({out_pc[0], out_exc[0], out_is_inst2}), 128'({32'h700, 4'h3, 2'b00}));
    out_ready = 1'b1;
    cyc();
    chk("t6_empty", 128'(out_valid), 128'(2'b00));

    // Random traffic: slow consumer first, then fast.
    for (int c = 0; c < 3000; c++) begin
      for (int l = 0; l < 2; l++) begin
        drive_lane(l, $urandom, operation_t'($urandom_range(0, 19)),
                   ($urandom_range(0, 7) == 0) ? exception_t'($urandom_range(1, 15)) : 4'd0);
      end
      in_valid  = 2'($urandom_range(0, 3));
      out_ready = (c < 1500) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
      flush     = ($urandom_range(0, 59) == 0);
      cyc();
    end
    flush = 1'b0; in_valid = 2'b00; out_ready = 1'b1;
    repeat (20) cyc();
    chk("final_empty", 128'(out_valid), 128'(2'b00));
    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
